// File: rtl/sram_sp_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single-port SRAM.
// Define SRAM_ARB_FIXED_PRI_EN to make requester 0 win every tie instead.
module sram_sp_arbiter #(
  parameter int depth = 10,
  parameter int width = 8,
  parameter int AW    = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             wr0,
  input  logic             wr1,
  input  logic [AW-1:0]    add0,
  input  logic [AW-1:0]    add1,
  input  logic [width-1:0] wdata0,
  input  logic [width-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             err0,
  output logic             err1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [width-1:0] rdata,
  output logic             sram_re,
  output logic             sram_we,
  output logic [AW-1:0]    sram_add,
  output logic [width-1:0] sram_data_in,
  input  logic [width-1:0] sram_data_out
);

  typedef enum logic {IDLE, CMD} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(depth);

  state_t             state_q, state_d;
  logic               last_gnt_q, last_gnt_d;
  logic               cmd_wr_q, cmd_wr_d;
  logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic               err0_q, err0_d, err1_q, err1_d;
  logic               rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [width-1:0]   rdata_q, rdata_d;
  logic               sram_re_q, sram_re_d, sram_we_q, sram_we_d;
  logic [AW-1:0]      sram_add_q, sram_add_d;
  logic [width-1:0]   sram_data_in_q, sram_data_in_d;

  logic               pick;
  logic               sel_wr;
  logic [AW-1:0]      sel_add;
  logic [width-1:0]   sel_wdata;
  logic               sel_oor;

  // Arbitration: pick = 1 selects requester 1.
  always_comb begin
`ifdef SRAM_ARB_FIXED_PRI_EN
    pick = !req0 && req1;
`else
    pick = req1 && (!req0 || !last_gnt_q);
`endif
    sel_wr    = pick ? wr1    : wr0;
    sel_add   = pick ? add1   : add0;
    sel_wdata = pick ? wdata1 : wdata0;
    sel_oor   = {1'b0, sel_add} >= DEPTH_L;
  end

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d        = state_q;
    last_gnt_d     = last_gnt_q;
    cmd_wr_d       = cmd_wr_q;
    rdata_d        = rdata_q;
    gnt0_d         = 1'b0;
    gnt1_d         = 1'b0;
    err0_d         = 1'b0;
    err1_d         = 1'b0;
    rvalid0_d      = 1'b0;
    rvalid1_d      = 1'b0;
    sram_re_d      = 1'b0;
    sram_we_d      = 1'b0;
    sram_add_d     = '0;
    sram_data_in_d = '0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d        = CMD;
          last_gnt_d     = pick;
          cmd_wr_d       = sel_wr;
          gnt0_d         = !pick;
          gnt1_d         = pick;
          err0_d         = !pick && sel_oor;
          err1_d         = pick && sel_oor;
          sram_we_d      = sel_wr && !sel_oor;
          sram_re_d      = !sel_wr && !sel_oor;
          sram_add_d     = sel_add;
          sram_data_in_d = sel_wdata;
        end
      end
      CMD: begin
        state_d = IDLE;
        // Out-of-range reads never raise sram_re, so they return zero.
        if (!cmd_wr_q) begin
          rdata_d   = sram_re_q ? sram_data_out : '0;
          rvalid0_d = gnt0_q;
          rvalid1_d = gnt1_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_gnt_q     <= 1'b1;
      cmd_wr_q       <= 1'b0;
      gnt0_q         <= 1'b0;
      gnt1_q         <= 1'b0;
      err0_q         <= 1'b0;
      err1_q         <= 1'b0;
      rvalid0_q      <= 1'b0;
      rvalid1_q      <= 1'b0;
      rdata_q        <= '0;
      sram_re_q      <= 1'b0;
      sram_we_q      <= 1'b0;
      sram_add_q     <= '0;
      sram_data_in_q <= '0;
    end else begin
      state_q        <= state_d;
      last_gnt_q     <= last_gnt_d;
      cmd_wr_q       <= cmd_wr_d;
      gnt0_q         <= gnt0_d;
      gnt1_q         <= gnt1_d;
      err0_q         <= err0_d;
      err1_q         <= err1_d;
      rvalid0_q      <= rvalid0_d;
      rvalid1_q      <= rvalid1_d;
      rdata_q        <= rdata_d;
      sram_re_q      <= sram_re_d;
      sram_we_q      <= sram_we_d;
      sram_add_q     <= sram_add_d;
      sram_data_in_q <= sram_data_in_d;
    end
  end

  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign err0         = err0_q;
  assign err1         = err1_q;
  assign rvalid0      = rvalid0_q;
  assign rvalid1      = rvalid1_q;
  assign rdata        = rdata_q;
  assign sram_re      = sram_re_q;
  assign sram_we      = sram_we_q;
  assign sram_add     = sram_add_q;
  assign sram_data_in = sram_data_in_q;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Directed bench for sram_sp_arbiter with a behavioural single-port SRAM model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sram_sp_arbiter;

  localparam int DEPTH = 10;
  localparam int W     = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] add0 = '0, add1 = '0;
  logic [W-1:0]  wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, err0, err1, rvalid0, rvalid1;
  logic [W-1:0]  rdata;
  logic          sram_re, sram_we;
  logic [AW-1:0] sram_add;
  logic [W-1:0]  sram_data_in;
  logic [W-1:0]  sram_data_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] mem [DEPTH];

  sram_sp_arbiter #(.depth(DEPTH), .width(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .add0(add0), .add1(add1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .sram_re(sram_re), .sram_we(sram_we), .sram_add(sram_add),
    .sram_data_in(sram_data_in), .sram_data_out(sram_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (sram_we && (int'(sram_add) < DEPTH)) mem[sram_add] <= sram_data_in;

  always_comb begin
    sram_data_out = '0;
    if (sram_re && (int'(sram_add) < DEPTH)) sram_data_out = mem[sram_add];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Invariants sampled every cycle
  always @(negedge clk) begin
    check("inv_we_re", 32'(sram_we & sram_re), 32'd0);
    check("inv_gnt", 32'(gnt0 & gnt1), 32'd0);
    check("inv_rvalid", 32'(rvalid0 & rvalid1), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic set_req(input bit who, input bit v, input bit wr, input logic [AW-1:0] a,
                         input logic [W-1:0] d);
    if (!who) begin req0 = v; wr0 = wr; add0 = a; wdata0 = d; end
    else      begin req1 = v; wr1 = wr; add1 = a; wdata1 = d; end
  endtask

  // One isolated access: grant cycle, then the cycle that carries rvalid for reads.
  task automatic access(input bit who, input bit wr, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input logic [W-1:0] exp_rd, input bit exp_err);
    set_req(who, 1'b1, wr, a, d);
    @(negedge clk);
    check("acc_gnt0", 32'(gnt0), 32'(!who));
    check("acc_gnt1", 32'(gnt1), 32'(who));
    check("acc_err", 32'(who ? err1 : err0), 32'(exp_err));
    check("acc_we", 32'(sram_we), 32'(wr && !exp_err));
    check("acc_re", 32'(sram_re), 32'(!wr && !exp_err));
    check("acc_add", 32'(sram_add), 32'(a));
    if (wr) check("acc_din", 32'(sram_data_in), 32'(d));
    set_req(who, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("acc_we_off", 32'(sram_we), 32'd0);
    check("acc_gnt_off", 32'(gnt0 | gnt1 | err0 | err1), 32'd0);
    check("acc_rvalid0", 32'(rvalid0), 32'(!wr && !who));
    check("acc_rvalid1", 32'(rvalid1), 32'(!wr && who));
    if (!wr) check("acc_rdata", 32'(rdata), 32'(exp_rd));
  endtask

  bit           exp_seq [4];
  logic [W-1:0] b2b_exp [3];

  initial begin
`ifdef SRAM_ARB_FIXED_PRI_EN
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    b2b_exp = '{8'h30, 8'h11, 8'h22};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'({gnt0, gnt1, err0, err1}), 32'd0);
    check("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_sram_ctl", 32'({sram_re, sram_we}), 32'd0);
    check("rst_sram_add", 32'(sram_add), 32'd0);
    check("rst_sram_din", 32'(sram_data_in), 32'd0);
    rst_n = 1'b1;

    // Basic write then read-back
    access(1'b0, 1'b1, 4'd3, 8'd25, 8'd0, 1'b0);
    access(1'b0, 1'b0, 4'd3, 8'd0, 8'd25, 1'b0);
    @(negedge clk);
    check("rdata_hold", 32'(rdata), 32'd25);
    check("rvalid_one_cycle", 32'(rvalid0), 32'd0);

    // Out-of-range read and write from requester 1
    access(1'b1, 1'b0, 4'd12, 8'd0, 8'd0, 1'b1);
    access(1'b1, 1'b1, 4'd10, 8'h5A, 8'd0, 1'b1);

    // Contention: both held for four grants
    set_req(1'b0, 1'b1, 1'b1, 4'd1, 8'h11);
    set_req(1'b1, 1'b1, 1'b1, 4'd2, 8'h22);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("arb_gnt0", 32'(gnt0), 32'(!exp_seq[i]));
      check("arb_gnt1", 32'(gnt1), 32'(exp_seq[i]));
      check("arb_add", 32'(sram_add), exp_seq[i] ? 32'd2 : 32'd1);
      if (i == 3) begin
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
      end
      @(negedge clk);
      check("arb_idle", 32'(gnt0 | gnt1), 32'd0);
    end
`ifdef SRAM_ARB_FIXED_PRI_EN
    access(1'b1, 1'b1, 4'd2, 8'h22, 8'd0, 1'b0);
`endif
    access(1'b0, 1'b0, 4'd1, 8'd0, 8'h11, 1'b0);
    access(1'b1, 1'b0, 4'd2, 8'd0, 8'h22, 1'b0);

    // Back-to-back reads from requester 0 with req held high
    access(1'b0, 1'b1, 4'd0, 8'h30, 8'd0, 1'b0);
    set_req(1'b0, 1'b1, 1'b0, 4'd0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b2b_gnt", 32'(gnt0), 32'd1);
      check("b2b_add", 32'(sram_add), 32'(i));
      if (i == 2) set_req(1'b0, 1'b0, 1'b0, '0, '0);
      else        add0 = AW'(i + 1);
      @(negedge clk);
      check("b2b_rvalid0", 32'(rvalid0), 32'd1);
      check("b2b_rvalid1", 32'(rvalid1), 32'd0);
      check("b2b_rdata", 32'(rdata), 32'(b2b_exp[i]));
      check("b2b_nognt", 32'(gnt0), 32'd0);
    end

    // Reset asserted during the CMD cycle of a read
    set_req(1'b0, 1'b1, 1'b0, 4'd1, '0);
    @(negedge clk);
    check("rstcmd_re", 32'(sram_re), 32'd1);
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check("rstcmd_re_drop", 32'(sram_re), 32'd0);
    check("rstcmd_gnt_drop", 32'(gnt0), 32'd0);
    check("rstcmd_rdata", 32'(rdata), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rstcmd_norvalid", 32'(rvalid0 | rvalid1), 32'd0);
    end
    rst_n = 1'b1;
    set_req(1'b0, 1'b1, 1'b1, 4'd4, 8'h44);
    set_req(1'b1, 1'b1, 1'b1, 4'd5, 8'h55);
    @(negedge clk);
    check("post_rst_gnt0", 32'(gnt0), 32'd1);
    check("post_rst_gnt1", 32'(gnt1), 32'd0);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    check("post_rst_rvalid", 32'(rvalid0 | rvalid1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
